// File: rtl/dbg_router_pkg.sv
// -----------------------------------------------------------------------------
// dbg_router_pkg
// Shared definitions for the debug port router: debug mode encodings, the
// router FSM state encoding and the width of its internal cycle counters.
// -----------------------------------------------------------------------------
package dbg_router_pkg;

  // Debug peripheral selection (cfg_mode / act_mode encoding)
  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_I2C  = 2'd1;
  localparam logic [1:0] MODE_UART = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Router FSM states
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DETECT = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Dead-time and debounce counters both hold values up to 255
  localparam int CNT_W = 8;

endpackage

// File: rtl/dbg_sync2.sv
// -----------------------------------------------------------------------------
// dbg_sync2
// Two-flop synchronizer for asynchronous pad inputs. Both stages reset to 1,
// the idle level of the I2C and UART lines.
//   clk  : destination clock
//   rstz : asynchronous active-low reset
//   d    : asynchronous input bus (W bits)
//   q    : synchronized output bus, two clk cycles behind d
// -----------------------------------------------------------------------------
module dbg_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstz,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      meta_p0 <= '1;
      q       <= '1;
    end else begin
      // stage p0: capture asynchronous input
      meta_p0 <= d;
      // stage p1: resolved, safe for core logic
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/dbg_port_router.sv
// -----------------------------------------------------------------------------
// dbg_port_router
// Routes the debug I2C slave or the debug UART onto one of NPAIR pad pairs
// (pair k = pad bits 2k, 2k+1) with optional orientation swap. Every change of
// route is break-before-make: all routed pads are released for DEAD_CYC cycles.
//
// Build option: define AUTO_ORIENT_EN to detect I2C orientation from the first
// START condition seen on the pair (adds the DETECT state and DBNC_CYC).
//
// Ports:
//   clk, rstz          core clock, asynchronous active-low reset
//   cfg_req            one-cycle pulse loading cfg_mode/cfg_pair/cfg_swap
//   cfg_mode           0 off, 1 I2C, 2 UART, 3 reserved (treated as off)
//   cfg_pair           target pad pair
//   cfg_swap           0: pin 2k = SCL/TX, 2k+1 = SDA/RX; 1: swapped
//   busy               high while draining or detecting orientation
//   cfg_err            one-cycle pulse after an illegal cfg_req
//   act_mode, act_swap route in effect (0 unless ACTIVE)
//   pad_di             asynchronous pad receive values
//   pad_do, pad_oe     pad drive value / drive enable
//   scl_oe, sda_oe     I2C slave pull-low requests
//   scl_i, sda_i       synchronized I2C lines to the slave
//   uart_tx, uart_rx   UART transmit in, synchronized receive out
// -----------------------------------------------------------------------------
module dbg_port_router
  import dbg_router_pkg::*;
#(
  parameter int NPAIR    = 3,
  parameter int DEAD_CYC = 16,
`ifdef AUTO_ORIENT_EN
  parameter int DBNC_CYC = 8,
`endif
  parameter int PW       = ($clog2(NPAIR) > 0) ? $clog2(NPAIR) : 1
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic               cfg_req,
  input  logic [1:0]         cfg_mode,
  input  logic [PW-1:0]      cfg_pair,
  input  logic               cfg_swap,
  output logic               busy,
  output logic               cfg_err,
  output logic [1:0]         act_mode,
  output logic               act_swap,
  input  logic [2*NPAIR-1:0] pad_di,
  output logic [2*NPAIR-1:0] pad_do,
  output logic [2*NPAIR-1:0] pad_oe,
  input  logic               scl_oe,
  input  logic               sda_oe,
  output logic               scl_i,
  output logic               sda_i,
  input  logic               uart_tx,
  output logic               uart_rx
);

  state_t             state;
  logic [CNT_W-1:0]   dead_cnt;
  logic [1:0]         pend_mode;
  logic [PW-1:0]      pend_pair;
  logic               pend_swap;
  logic [1:0]         act_mode_q;
  logic [PW-1:0]      act_pair;
  logic               act_swap_q;
  logic               cfg_err_q;
  logic [2*NPAIR-1:0] pad_sync;
  logic               legal;
  logic               go_drain;
  logic               active;
  logic [NPAIR-1:0]   scl_v, sda_v, rx_v;

  dbg_sync2 #(.W(2*NPAIR)) u_sync (
    .clk  (clk),
    .rstz (rstz),
    .d    (pad_di),
    .q    (pad_sync)
  );

  assign legal  = (int'(cfg_pair) < NPAIR) && (cfg_mode != MODE_RSVD);
  assign active = (state == ST_ACTIVE);
  // From OFF only a legal, non-off request starts a route; from any other
  // state every request (illegal ones become "off") restarts the dead time.
  assign go_drain = cfg_req &&
                    ((state != ST_OFF) || (legal && (cfg_mode != MODE_OFF)));

  assign busy     = (state == ST_DRAIN) || (state == ST_DETECT);
  assign cfg_err  = cfg_err_q;
  assign act_mode = active ? act_mode_q : MODE_OFF;
  assign act_swap = active && act_swap_q;

  // Per-pair drive and receive. Unselected pairs contribute 1 to the receive
  // reductions, so the AND across pairs yields the selected pair's value.
  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    logic sel, i2c, uart;
    assign sel  = active && (act_pair == PW'(k));
    assign i2c  = sel && (act_mode_q == MODE_I2C);
    assign uart = sel && (act_mode_q == MODE_UART);

    assign pad_oe[2*k]   = i2c ? (act_swap_q ? sda_oe : scl_oe) : (uart && !act_swap_q);
    assign pad_oe[2*k+1] = i2c ? (act_swap_q ? scl_oe : sda_oe) : (uart &&  act_swap_q);
    assign pad_do[2*k]   = uart && !act_swap_q && uart_tx;
    assign pad_do[2*k+1] = uart &&  act_swap_q && uart_tx;

    assign scl_v[k] = i2c  ? (act_swap_q ? pad_sync[2*k+1] : pad_sync[2*k])   : 1'b1;
    assign sda_v[k] = i2c  ? (act_swap_q ? pad_sync[2*k]   : pad_sync[2*k+1]) : 1'b1;
    assign rx_v[k]  = uart ? (act_swap_q ? pad_sync[2*k]   : pad_sync[2*k+1]) : 1'b1;
  end

  assign scl_i   = &scl_v;
  assign sda_i   = &sda_v;
  assign uart_rx = &rx_v;

`ifdef AUTO_ORIENT_EN
  logic [CNT_W-1:0] dbnc_cnt;
  logic             armed;
  logic [NPAIR-1:0] lo_v, hi_v;
  logic             pin_lo, pin_hi;

  for (genvar k = 0; k < NPAIR; k++) begin : g_det
    assign lo_v[k] = (act_pair == PW'(k)) && pad_sync[2*k];
    assign hi_v[k] = (act_pair == PW'(k)) && pad_sync[2*k+1];
  end

  assign pin_lo = |lo_v;
  assign pin_hi = |hi_v;
`endif

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state      <= ST_OFF;
      dead_cnt   <= '0;
      pend_mode  <= MODE_OFF;
      pend_pair  <= '0;
      pend_swap  <= 1'b0;
      act_mode_q <= MODE_OFF;
      act_pair   <= '0;
      act_swap_q <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef AUTO_ORIENT_EN
      dbnc_cnt   <= '0;
      armed      <= 1'b0;
`endif
    end else begin
      cfg_err_q <= cfg_req && !legal;
      if (go_drain) begin
        pend_mode <= legal ? cfg_mode : MODE_OFF;
        pend_pair <= cfg_pair;
        pend_swap <= cfg_swap;
        dead_cnt  <= CNT_W'(DEAD_CYC);
        state     <= ST_DRAIN;
      end else begin
        case (state)
          ST_DRAIN: begin
            if (dead_cnt == CNT_W'(1)) begin
              if (pend_mode == MODE_OFF) begin
                state <= ST_OFF;
              end else begin
                act_mode_q <= pend_mode;
                act_pair   <= pend_pair;
                act_swap_q <= pend_swap;
`ifdef AUTO_ORIENT_EN
                if (pend_mode == MODE_I2C) begin
                  state    <= ST_DETECT;
                  dbnc_cnt <= '0;
                  armed    <= 1'b0;
                end else begin
                  state <= ST_ACTIVE;
                end
`else
                state <= ST_ACTIVE;
`endif
              end
            end else begin
              dead_cnt <= dead_cnt - CNT_W'(1);
            end
          end
`ifdef AUTO_ORIENT_EN
          // Debounce the idle bus, then the first pin to fall alone is SDA
          // (START). Both falling together is ambiguous: start over.
          ST_DETECT: begin
            if (!armed) begin
              if (pin_lo && pin_hi) begin
                if (dbnc_cnt == CNT_W'(DBNC_CYC - 1)) armed <= 1'b1;
                else dbnc_cnt <= dbnc_cnt + CNT_W'(1);
              end else begin
                dbnc_cnt <= '0;
              end
            end else if (!pin_lo && !pin_hi) begin
              armed    <= 1'b0;
              dbnc_cnt <= '0;
            end else if (pin_lo != pin_hi) begin
              act_swap_q <= !pin_lo;
              armed      <= 1'b0;
              state      <= ST_ACTIVE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbg_port_router.sv
// -----------------------------------------------------------------------------
// tb_dbg_port_router
// Directed bench for dbg_port_router with default parameters (NPAIR=3,
// DEAD_CYC=16). Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dbg_port_router;

  logic       clk = 1'b0;
  logic       rstz = 1'b1;
  logic       cfg_req = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [1:0] cfg_pair = 2'd0;
  logic       cfg_swap = 1'b0;
  logic       busy, cfg_err, act_swap;
  logic [1:0] act_mode;
  logic [5:0] pad_di = 6'b111111;
  logic [5:0] pad_do, pad_oe;
  logic       scl_oe = 1'b0, sda_oe = 1'b0;
  logic       scl_i, sda_i, uart_rx;
  logic       uart_tx = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbg_port_router dut (
    .clk      (clk),
    .rstz     (rstz),
    .cfg_req  (cfg_req),
    .cfg_mode (cfg_mode),
    .cfg_pair (cfg_pair),
    .cfg_swap (cfg_swap),
    .busy     (busy),
    .cfg_err  (cfg_err),
    .act_mode (act_mode),
    .act_swap (act_swap),
    .pad_di   (pad_di),
    .pad_do   (pad_do),
    .pad_oe   (pad_oe),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge after the request
  // was sampled.
  task automatic req(input logic [1:0] m, input logic [1:0] p, input logic s);
    cfg_mode = m;
    cfg_pair = p;
    cfg_swap = s;
    cfg_req  = 1'b1;
    @(negedge clk);
    cfg_req  = 1'b0;
  endtask

  // Exactly 16 samples of released pads and busy, ending on the first sample
  // after the dead time.
  task automatic drain_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_oe"}, pad_oe, 0);
      tick(1);
    end
  endtask

`ifdef AUTO_ORIENT_EN
  // Produce a START on the pair so orientation resolves to swap s.
  task automatic settle(input int p, input logic s);
    int idx;
    idx = s ? 2*p : 2*p + 1;
    tick(12);
    pad_di[idx[2:0]] = 1'b0;
    tick(4);
    pad_di[idx[2:0]] = 1'b1;
    tick(3);
  endtask
`endif

  initial begin
    // reset
    #2 rstz = 1'b0;
    #1;
    chk("rst_oe", pad_oe, 0);
    chk("rst_do", pad_do, 0);
    chk("rst_scl", scl_i, 1);
    chk("rst_sda", sda_i, 1);
    chk("rst_rx", uart_rx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_mode", act_mode, 0);
    chk("rst_swap", act_swap, 0);
    tick(3);
    rstz = 1'b1;
    tick(2);
    chk("idle_busy", busy, 0);

    // I2C pair 1, no swap
    req(2'd1, 2'd1, 1'b0);
    chk("t1_err", cfg_err, 0);
    drain_check("t1");
`ifdef AUTO_ORIENT_EN
    settle(1, 1'b0);
`endif
    chk("t1_busy_end", busy, 0);
    chk("t1_mode", act_mode, 1);
    chk("t1_swap", act_swap, 0);
    scl_oe = 1'b1;
    #1 chk("t1_scl_oe", pad_oe, 6'b000100);
    chk("t1_do", pad_do, 0);
    sda_oe = 1'b1;
    #1 chk("t1_sda_oe", pad_oe, 6'b001100);
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    #1 chk("t1_oe_off", pad_oe, 0);
    tick(1);
    pad_di[3] = 1'b0;
    tick(1);
    chk("t1_sda_lat1", sda_i, 1);
    tick(1);
    chk("t1_sda_lat2", sda_i, 0);
    chk("t1_scl_hi", scl_i, 1);
    pad_di[3] = 1'b1;
    tick(2);
    chk("t1_sda_back", sda_i, 1);

    // UART pair 2, swapped
    req(2'd2, 2'd2, 1'b1);
    drain_check("t2");
    chk("t2_mode", act_mode, 2);
    chk("t2_swap", act_swap, 1);
    uart_tx = 1'b1;
    #1 chk("t2_oe", pad_oe, 6'b100000);
    chk("t2_do1", pad_do, 6'b100000);
    uart_tx = 1'b0;
    #1 chk("t2_do0", pad_do, 0);
    chk("t2_oe0", pad_oe, 6'b100000);
    tick(1);
    pad_di[4] = 1'b0;
    tick(1);
    chk("t2_rx_lat1", uart_rx, 1);
    tick(1);
    chk("t2_rx_lat2", uart_rx, 0);
    chk("t2_scl", scl_i, 1);
    chk("t2_sda", sda_i, 1);
    pad_di[4] = 1'b1;
    tick(2);
    chk("t2_rx_back", uart_rx, 1);

    // break-before-make: I2C pair 0 -> UART pair 1
    req(2'd1, 2'd0, 1'b0);
    drain_check("t3a");
`ifdef AUTO_ORIENT_EN
    settle(0, 1'b0);
`endif
    chk("t3_mode_i2c", act_mode, 1);
    scl_oe = 1'b1;
    sda_oe = 1'b1;
    #1 chk("t3_oe_i2c", pad_oe, 6'b000011);
    tick(1);
    cfg_mode = 2'd2;
    cfg_pair = 2'd1;
    cfg_swap = 1'b0;
    cfg_req  = 1'b1;
    #1 chk("t3_oe_hold", pad_oe, 6'b000011);
    @(negedge clk);
    cfg_req = 1'b0;
    drain_check("t3b");
    uart_tx = 1'b1;
    #1 chk("t3_oe_uart", pad_oe, 6'b000100);
    chk("t3_do_uart", pad_do, 6'b000100);
    chk("t3_mode_uart", act_mode, 2);
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    tick(1);

    // back to OFF, illegal requests, re-request during DRAIN
    req(2'd0, 2'd0, 1'b0);
    drain_check("t4off");
    chk("t4_off_busy", busy, 0);
    chk("t4_off_mode", act_mode, 0);
    chk("t4_off_oe", pad_oe, 0);
    req(2'd1, 2'd3, 1'b0);
    chk("t4_err_pair", cfg_err, 1);
    chk("t4_err_busy", busy, 0);
    tick(1);
    chk("t4_err_pulse", cfg_err, 0);
    chk("t4_err_busy2", busy, 0);
    req(2'd3, 2'd0, 1'b0);
    chk("t4_err_mode", cfg_err, 1);
    chk("t4_err_mbusy", busy, 0);
    tick(1);
    chk("t4_err_mpulse", cfg_err, 0);
    req(2'd2, 2'd0, 1'b0);
    chk("t4_first_busy", busy, 1);
    chk("t4_first_err", cfg_err, 0);
    tick(4);
    req(2'd2, 2'd1, 1'b1);
    chk("t4_second_err", cfg_err, 0);
    drain_check("t4re");
    chk("t4_mode", act_mode, 2);
    chk("t4_swap", act_swap, 1);
    #1 chk("t4_oe", pad_oe, 6'b001000);
    chk("t4_do", pad_do, 6'b001000);
    tick(1);
    req(2'd1, 2'd3, 1'b0);
    chk("t4_act_err", cfg_err, 1);
    drain_check("t4ill");
    chk("t4_ill_busy", busy, 0);
    chk("t4_ill_mode", act_mode, 0);
    chk("t4_ill_oe", pad_oe, 0);
    chk("t4_ill_err", cfg_err, 0);

`ifdef AUTO_ORIENT_EN
    // orientation detect on pair 1
    scl_oe = 1'b1;
    req(2'd1, 2'd1, 1'b0);
    drain_check("t5");
    chk("t5_det_busy", busy, 1);
    chk("t5_det_mode", act_mode, 0);
    chk("t5_det_oe", pad_oe, 0);
    tick(12);
    pad_di[3:2] = 2'b00;
    tick(4);
    chk("t5_both_busy", busy, 1);
    chk("t5_both_mode", act_mode, 0);
    pad_di[3:2] = 2'b11;
    tick(14);
    pad_di[2] = 1'b0;
    tick(4);
    chk("t5_busy", busy, 0);
    chk("t5_mode", act_mode, 1);
    chk("t5_swap", act_swap, 1);
    chk("t5_sda_lo", sda_i, 0);
    chk("t5_scl_hi", scl_i, 1);
    #1 chk("t5_oe", pad_oe, 6'b001000);
    pad_di[2] = 1'b1;
    tick(2);
    chk("t5_sda_hi", sda_i, 1);
    scl_oe = 1'b0;
    tick(1);
`endif

    // asynchronous reset while UART is active
    uart_tx = 1'b1;
    req(2'd2, 2'd0, 1'b0);
    drain_check("t6");
    #1 chk("t6_oe", pad_oe, 6'b000001);
    tick(1);
    pad_di[1] = 1'b0;
    tick(2);
    chk("t6_rx_lo", uart_rx, 0);
    #2 rstz = 1'b0;
    #1 chk("t6_rst_oe", pad_oe, 0);
    chk("t6_rst_do", pad_do, 0);
    chk("t6_rst_rx", uart_rx, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_mode", act_mode, 0);
    tick(2);
    rstz = 1'b1;
    pad_di = 6'b111111;
    tick(2);
    chk("t6_post_oe", pad_oe, 0);
    chk("t6_post_mode", act_mode, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_port_router.md
Name: dbg_port_router

Overview:
- Parametrised routing block that places the on-chip debug I2C slave or debug UART onto one of NPAIR pin pairs, e.g. GPIO1/2, CC1/CC2 or DP/DN, with optional orientation swap.
- Replaces the fixed, per-pin routing enables with one register-driven router.
- Switching is break-before-make, using a programmable dead time.
- Sits between the MCU debug peripherals and the pad/analog pin muxing in the core.

Parameters:
- NPAIR, 3, number of selectable pin pairs (pair k = pad bits 2k, 2k+1).
- DEAD_CYC, 16, clk cycles with all routed pads released between configurations (1..255).
- DBNC_CYC, 8, consecutive idle-high cycles required before orientation detect arms (only with AUTO_ORIENT_EN).
- PW, $clog2(NPAIR)>0 ? $clog2(NPAIR) : 1, width of the pair selector.

Ports:
- clk  in  1  core clock
- rstz  in  1  async active-low reset
- cfg_req  in  1  one-cycle pulse: load cfg_*
- cfg_mode  in  2  0=off, 1=I2C, 2=UART, 3=reserved (treated as off)
- cfg_pair  in  PW  target pair
- cfg_swap  in  1  0: bit 2k=SCL/TX, 2k+1=SDA/RX; 1: swapped
- busy  out  1  high in DRAIN or DETECT
- cfg_err  out  1  one-cycle pulse: cfg_pair>=NPAIR or mode 3
- act_mode  out  2  mode in effect (0 unless ACTIVE)
- act_swap  out  1  orientation in effect
- pad_di  in  2*NPAIR  pad receive (asynchronous)
- pad_do  out  2*NPAIR  pad drive value
- pad_oe  out  2*NPAIR  pad drive enable
- scl_oe  in  1  I2C slave pulls SCL low
- sda_oe  in  1  I2C slave pulls SDA low
- scl_i  out  1  to I2C slave
- sda_i  out  1  to I2C slave
- uart_tx  in  1  from UART
- uart_rx  out  1  to UART

Behaviour:
- Reset:
  - state OFF.
  - pad_oe=0, pad_do=0.
  - scl_i=sda_i=uart_rx=1.
  - busy=0, cfg_err=0, act_mode=0, act_swap=0.
- Input sync: pad_di passes through a 2-flop synchronizer (reset value 1). Pad-to-core latency is 2 cycles.
- Pad drive is combinational from the registered state and the core inputs, for unrouted pairs and routed pairs alike:
  - I2C: pad_do=0; pad_oe[scl pin]=scl_oe; pad_oe[sda pin]=sda_oe.
  - UART: tx pin oe=1, do=uart_tx; rx pin oe=0.
  - Unrouted pads: oe=0, do=0.
- Core inputs:
  - ACTIVE I2C: scl_i/sda_i = synced pad of the mapped pin.
  - ACTIVE UART: uart_rx = synced rx pin.
  - All other cases, including scl_i/sda_i in UART mode: 1.
- FSM (registered):
  - OFF: on a legal cfg_req with mode!=0, latch cfg into pending, load dead counter = DEAD_CYC, go DRAIN.
  - ACTIVE: any cfg_req (legal, or illegal with cfg_err) latches pending and goes DRAIN. Illegal or off becomes pending mode 0. The current route is released the next cycle.
  - DRAIN: all pads released; counter decrements each cycle. At 1:
    - pending mode 0 → OFF;
    - else → ACTIVE (or DETECT, see option).
    - Elapsed DRAIN time is exactly DEAD_CYC cycles.
  - cfg_req during DRAIN re-latches pending and reloads the counter.
  - Illegal cfg_req in OFF: cfg_err pulse, stay OFF.
- cfg_err asserts the cycle after the offending cfg_req.
- act_mode/act_swap update on entry to ACTIVE.
- Reset mid-operation: pads release asynchronously to the reset values.

Optional Feature:
- Macro: AUTO_ORIENT_EN.
- With the macro, I2C entry goes DRAIN→DETECT (busy=1, pads released, core inputs 1) and cfg_swap is ignored for I2C:
  - Arm: both synced pins of the pair high for DBNC_CYC consecutive cycles; any low restarts the count.
  - Once armed, the first pin seen falling alone is SDA (START condition). act_swap = (the falling pin is 2k), then go ACTIVE.
  - Both pins falling in the same cycle: disarm and re-debounce.
  - cfg_req in DETECT behaves as in ACTIVE.
- Without the macro, the DETECT state and its counter are absent and cfg_swap is used directly.

Decomposition:
- Package dbg_router_pkg: mode encodings (MODE_OFF/I2C/UART), FSM state enum (OFF, DRAIN, DETECT, ACTIVE), counter width constants.
- One sub-module, dbg_sync2: 2-flop synchronizer, width-parametrised, async active-low reset to 1.

Test Plan:
- Reset, then cfg_req mode=1 pair=1 swap=0 → busy=1 for 16 cycles. Then ACTIVE. scl_oe=1 → pad_oe[2]=1, pad_do[2]=0. Pad 3 low → sda_i=0 two cycles later.
- UART on pair 2 with swap=1 → pad_oe[5]=1, pad_do[5] follows uart_tx. pad_di[4] toggles → uart_rx follows after 2 cycles. pad_oe[4]=0.
- ACTIVE I2C pair 0, then cfg_req UART pair 1 → pad_oe of pair 0 drops the next cycle. No pad_oe asserted for 16 cycles, then pair 1 is driven.
- cfg_pair=3 (NPAIR=3) → cfg_err single pulse, state unchanged. Second cfg_req arriving 5 cycles into DRAIN → DRAIN extends to 16 cycles after the second request.
- AUTO_ORIENT_EN, I2C pair 1, both pins high 8 cycles, then pad 2 falls while pad 3 is high → act_swap=1, ACTIVE, sda_i tracks pad 2. Same-cycle fall of both pins → stays in DETECT.
- Assert rstz low while UART is ACTIVE → pad_oe=0 immediately; uart_rx=1.
